// File: rtl/comparador_serial_n.sv
// Serial magnitude comparator: CHUNK bits per clock, MSB chunk first,
// early exit on the first differing chunk, optional two's-complement mode.
module comparador_serial_n #(
    parameter int WIDTH     = 16,
    parameter int CHUNK     = 4,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             AmaiorB,
    output logic             AmenorB,
    output logic             AigualB
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        FIN
    } state_t;

    state_t stateQ, stateNext;

    logic [WIDTH-1:0] aReg, bReg;
    logic [IW-1:0]    idx;
    logic             gtReg, ltReg, eqReg;
    logic [CHUNK-1:0] aChunk, bChunk;
    logic             flip;
    logic             chGt, chLt, chEq, lastIdx;

    // Mode register and MSB inversion only exist when signed support is built.
    if (SIGNED_EN) begin : gSigned
        logic sgnReg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                sgnReg <= 1'b0;
            else if (stateQ == IDLE && start)
                sgnReg <= signed_mode;
        end
        assign flip = sgnReg && (idx == LAST);
    end else begin : gUnsigned
        assign flip = 1'b0;
    end

    always_comb begin
        aChunk = '0;
        bChunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IW'(i)) begin
                aChunk = aReg[i*CHUNK +: CHUNK];
                bChunk = bReg[i*CHUNK +: CHUNK];
            end
        end
        aChunk[CHUNK-1] = aChunk[CHUNK-1] ^ flip;
        bChunk[CHUNK-1] = bChunk[CHUNK-1] ^ flip;
    end

    assign chGt    = aChunk > bChunk;
    assign chLt    = aChunk < bChunk;
    assign chEq    = !(chGt || chLt);
    assign lastIdx = (idx == '0);

    always_comb begin
        stateNext = stateQ;
        unique case (1'b1)
            stateQ == IDLE:    if (start) stateNext = COMPARE;
            stateQ == COMPARE: if (!chEq || lastIdx) stateNext = FIN;
            stateQ == FIN:     stateNext = IDLE;
            default:           stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= IDLE;
            aReg   <= '0;
            bReg   <= '0;
            idx    <= '0;
            gtReg  <= 1'b0;
            ltReg  <= 1'b0;
            eqReg  <= 1'b0;
        end else begin
            stateQ <= stateNext;
            if (stateQ == IDLE && start) begin
                aReg  <= A;
                bReg  <= B;
                idx   <= LAST;
                gtReg <= 1'b0;
                ltReg <= 1'b0;
                eqReg <= 1'b0;
            end else if (stateQ == COMPARE) begin
                if (chGt)
                    gtReg <= 1'b1;
                else if (chLt)
                    ltReg <= 1'b1;
                else if (lastIdx)
                    eqReg <= 1'b1;
                else
                    idx <= idx - 1'b1;
            end
        end
    end

    assign busy    = (stateQ == COMPARE);
    assign done    = (stateQ == FIN);
    assign AmaiorB = gtReg;
    assign AmenorB = ltReg;
    assign AigualB = eqReg;

endmodule

// File: tb/tb_comparador_serial_n.sv
// Directed bench for comparador_serial_n across four parameter sets
// sharing one stimulus bus.
module tb_comparador_serial_n;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sm;
    logic [15:0] A, B;

    logic busy16, done16, gt16, lt16, eq16;
    logic busy4,  done4,  gt4,  lt4,  eq4;
    logic busy8,  done8,  gt8,  lt8,  eq8;
    logic busyU,  doneU,  gtU,  ltU,  eqU;

    int nCmp = 0;
    int nBad = 0;

    always #5 clk = ~clk;

    comparador_serial_n #(.WIDTH(16), .CHUNK(4), .SIGNED_EN(1'b1)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm),
        .A(A), .B(B), .busy(busy16), .done(done16),
        .AmaiorB(gt16), .AmenorB(lt16), .AigualB(eq16));

    comparador_serial_n #(.WIDTH(4), .CHUNK(4), .SIGNED_EN(1'b1)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm),
        .A(A[3:0]), .B(B[3:0]), .busy(busy4), .done(done4),
        .AmaiorB(gt4), .AmenorB(lt4), .AigualB(eq4));

    comparador_serial_n #(.WIDTH(8), .CHUNK(1), .SIGNED_EN(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm),
        .A(A[7:0]), .B(B[7:0]), .busy(busy8), .done(done8),
        .AmaiorB(gt8), .AmenorB(lt8), .AigualB(eq8));

    comparador_serial_n #(.WIDTH(16), .CHUNK(4), .SIGNED_EN(1'b0)) dutU (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm),
        .A(A), .B(B), .busy(busyU), .done(doneU),
        .AmaiorB(gtU), .AmenorB(ltU), .AigualB(eqU));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic selDone(input int sel);
        case (sel)
            0: return done16;
            1: return done4;
            2: return done8;
            default: return doneU;
        endcase
    endfunction

    function automatic logic selBusy(input int sel);
        case (sel)
            0: return busy16;
            1: return busy4;
            2: return busy8;
            default: return busyU;
        endcase
    endfunction

    function automatic logic [2:0] selFlags(input int sel);
        case (sel)
            0: return {gt16, lt16, eq16};
            1: return {gt4, lt4, eq4};
            2: return {gt8, lt8, eq8};
            default: return {gtU, ltU, eqU};
        endcase
    endfunction

    function automatic logic anyActive();
        return busy16 | busy4 | busy8 | busyU | done16 | done4 | done8 | doneU;
    endfunction

    task automatic waitIdle();
        for (int w = 0; w < 30 && anyActive(); w++) tick();
    endtask

    // One start pulse; reports the edge on which done rose (-1 if never)
    task automatic go(input int sel, input logic [15:0] a, input logic [15:0] b,
                      input logic s, output int edges, output int busyCyc,
                      output logic [2:0] fl);
        waitIdle();
        A = a; B = b; sm = s; start = 1'b1;
        edges = -1; busyCyc = 0; fl = 3'bxxx;
        for (int e = 1; e <= 40; e++) begin
            tick();
            start = 1'b0;
            if (selDone(sel)) begin
                edges = e;
                fl = selFlags(sel);
                break;
            end
            if (selBusy(sel)) busyCyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sm = 1'b0; A = '0; B = '0;
        #3;
        nCmp++;
        if ({busy16, done16, gt16, lt16, eq16} !== 5'b0) begin
            nBad++;
            $display("FAIL reset16 got %b want 00000", {busy16, done16, gt16, lt16, eq16});
        end
        nCmp++;
        if ({busy8, done8, gt8, lt8, eq8, busy4, done4, gt4, lt4, eq4} !== 10'b0) begin
            nBad++;
            $display("FAIL reset_small got %b want 0", {busy8, done8, gt8, lt8, eq8, busy4, done4, gt4, lt4, eq4});
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_equal();
        int ed, bc;
        logic [2:0] fl;
        go(0, 16'h1234, 16'h1234, 1'b0, ed, bc, fl);
        nCmp++;
        if (ed !== 5) begin nBad++; $display("FAIL eq_edges got %0d want 5", ed); end
        nCmp++;
        if (bc !== 4) begin nBad++; $display("FAIL eq_busy got %0d want 4", bc); end
        nCmp++;
        if (fl !== 3'b001) begin nBad++; $display("FAIL eq_flags got %b want 001", fl); end
        tick();
        nCmp++;
        if ({done16, gt16, lt16, eq16} !== 4'b0001) begin
            nBad++;
            $display("FAIL eq_hold got %b want 0001", {done16, gt16, lt16, eq16});
        end
    endtask

    task automatic test_signed();
        int ed, bc;
        logic [2:0] fl;
        go(0, 16'h9000, 16'h1FFF, 1'b0, ed, bc, fl);
        nCmp++;
        if (ed !== 2 || fl !== 3'b100) begin
            nBad++; $display("FAIL uns_9000 got edges=%0d flags=%b want 2/100", ed, fl);
        end
        tick();
        A = 16'h9000; B = 16'h1FFF; sm = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        nCmp++;
        if ({busy16, gt16, lt16, eq16} !== 4'b1000) begin
            nBad++; $display("FAIL clear_on_start got %b want 1000", {busy16, gt16, lt16, eq16});
        end
        ed = -1;
        for (int e = 2; e <= 20; e++) begin
            if (done16) begin ed = e - 1; break; end
            tick();
        end
        nCmp++;
        if (ed !== 2 || {gt16, lt16, eq16} !== 3'b010) begin
            nBad++; $display("FAIL sgn_9000 got edges=%0d flags=%b want 2/010", ed, {gt16, lt16, eq16});
        end
        go(3, 16'h9000, 16'h1FFF, 1'b1, ed, bc, fl);
        nCmp++;
        if (ed !== 2 || fl !== 3'b100) begin
            nBad++; $display("FAIL nosigned got edges=%0d flags=%b want 2/100", ed, fl);
        end
    endtask

    task automatic test_midchange();
        int ed = -1;
        waitIdle();
        A = 16'h12F0; B = 16'h12E0; sm = 1'b0; start = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            start = 1'b0;
            A = 16'h0000; B = 16'hFFFF; sm = 1'b1;
            if (done16) begin ed = e; break; end
        end
        nCmp++;
        if (ed !== 4 || {gt16, lt16, eq16} !== 3'b100) begin
            nBad++; $display("FAIL midchange got edges=%0d flags=%b want 4/100", ed, {gt16, lt16, eq16});
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int ed = -1;
        logic [2:0] fl = 3'b000;
        waitIdle();
        A = 16'h1234; B = 16'h1234; sm = 1'b0; start = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 1) begin A = 16'hFFFF; B = 16'h0000; end
            if (e == 3) start = 1'b0;
            if (done16) begin
                pulses++; ed = e; fl = {gt16, lt16, eq16};
            end
        end
        nCmp++;
        if (pulses !== 1 || ed !== 5) begin
            nBad++; $display("FAIL busy_start got pulses=%0d edge=%0d want 1/5", pulses, ed);
        end
        nCmp++;
        if (fl !== 3'b001) begin nBad++; $display("FAIL busy_start_flags got %b want 001", fl); end
    endtask

    task automatic test_midreset();
        int pulses = 0;
        waitIdle();
        A = 16'h1234; B = 16'h1234; sm = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        nCmp++;
        if ({busy16, done16, gt16, lt16, eq16} !== 5'b0) begin
            nBad++; $display("FAIL midreset got %b want 00000", {busy16, done16, gt16, lt16, eq16});
        end
        tick(); tick();
        rst_n = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (done16 || busy16) pulses++;
        end
        nCmp++;
        if (pulses !== 0) begin nBad++; $display("FAIL postreset_activity got %0d want 0", pulses); end
    endtask

    task automatic test_exhaustive4();
        int ed, bc;
        logic [2:0] fl, ex;
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    logic [3:0] a4, b4;
                    a4 = 4'(a); b4 = 4'(b);
                    if (s == 1)
                        ex = {$signed(a4) > $signed(b4), $signed(a4) < $signed(b4), a4 == b4};
                    else
                        ex = {a4 > b4, a4 < b4, a4 == b4};
                    go(1, {12'h000, a4}, {12'h000, b4}, s[0], ed, bc, fl);
                    nCmp++;
                    if (ed !== 2 || fl !== ex) begin
                        nBad++;
                        $display("FAIL w4 s=%0d a=%h b=%h got edges=%0d flags=%b want 2/%b",
                                 s, a4, b4, ed, fl, ex);
                    end
                end
            end
        end
    endtask

    task automatic test_chunk1();
        int ed, bc;
        logic [2:0] fl;
        go(2, 16'h0080, 16'h007F, 1'b1, ed, bc, fl);
        nCmp++;
        if (ed !== 2 || fl !== 3'b010) begin
            nBad++; $display("FAIL w8_sgn got edges=%0d flags=%b want 2/010", ed, fl);
        end
        go(2, 16'h0080, 16'h007F, 1'b0, ed, bc, fl);
        nCmp++;
        if (ed !== 2 || fl !== 3'b100) begin
            nBad++; $display("FAIL w8_uns got edges=%0d flags=%b want 2/100", ed, fl);
        end
        go(2, 16'h00FF, 16'h00FF, 1'b1, ed, bc, fl);
        nCmp++;
        if (ed !== 9 || fl !== 3'b001) begin
            nBad++; $display("FAIL w8_eq got edges=%0d flags=%b want 9/001", ed, fl);
        end
        go(2, 16'h00FE, 16'h00FF, 1'b1, ed, bc, fl);
        nCmp++;
        if (ed !== 9 || fl !== 3'b010) begin
            nBad++; $display("FAIL w8_lsb got edges=%0d flags=%b want 9/010", ed, fl);
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_signed();
        test_midchange();
        test_back_to_back();
        test_midreset();
        test_exhaustive4();
        test_chunk1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
